// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if
//   Handshake and operand/result bundle for the sequential Booth multiplier.
//   master : requester (execute stage) - drives start and operands.
//   slave  : booth_mult_seq            - drives busy, done, product (and ovf).
//   Optional: MULT_OVF_FLAG_EN adds the ovf signal to both modports.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
`ifdef MULT_OVF_FLAG_EN
  logic                   ovf;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product, ovf
  );
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product, ovf
  );
`else
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Radix-2 Booth sequential signed multiplier, one Booth step per clock,
//   WIDTH steps per product. All outputs registered.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset (abandons an in-flight product)
//     bus  - booth_mult_seq_if.slave: start, multiplicand, multiplier in;
//            busy, done (1-cycle pulse), product (held), ovf out
//   Optional: MULT_OVF_FLAG_EN adds ovf (product does not fit WIDTH signed).
//
//   state  | meaning
//   S_IDLE | waiting for start; done may be pulsing this cycle
//   S_RUN  | iterating Booth steps, busy=1
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_seq_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH:0]       r_a, w_a_nxt;
  logic [WIDTH:0]       r_m, w_m_nxt;
  logic [WIDTH-1:0]     r_q, w_q_nxt;
  logic                 r_q1, w_q1_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [2*WIDTH-1:0]   r_prod, w_prod_nxt;

  logic [WIDTH:0]       w_s;
  logic [WIDTH:0]       w_a_sh;
  logic [WIDTH-1:0]     w_q_sh;
  logic [2*WIDTH-1:0]   w_prod_fin;

  // Booth select on {Qr[0], q_1}; the extra accumulator bit keeps
  // M = -2^(WIDTH-1) exact. Carry-out beyond WIDTH+1 bits is dropped.
  always_comb begin
    w_s = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_s = r_a + r_m;
      2'b10:   w_s = r_a + ~r_m + {{WIDTH{1'b0}}, 1'b1};
      default: w_s = r_a;
    endcase
  end

  assign w_a_sh     = {w_s[WIDTH], w_s[WIDTH:1]};
  assign w_q_sh     = {w_s[0], r_q[WIDTH-1:1]};
  assign w_prod_fin = {w_a_sh[WIDTH-1:0], w_q_sh};

`ifdef MULT_OVF_FLAG_EN
  logic r_ovf, w_ovf_nxt;
  logic w_ovf_fin;
  // Fits in WIDTH signed bits only when the top WIDTH+1 bits are a pure sign run.
  assign w_ovf_fin = ~((&w_prod_fin[2*WIDTH-1:WIDTH-1]) |
                       ~(|w_prod_fin[2*WIDTH-1:WIDTH-1]));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= '0;
`ifdef MULT_OVF_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_m     <= w_m_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_prod  <= w_prod_nxt;
`ifdef MULT_OVF_FLAG_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_m_nxt     = r_m;
    w_q_nxt     = r_q;
    w_q1_nxt    = r_q1;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_prod_nxt  = r_prod;
`ifdef MULT_OVF_FLAG_EN
    w_ovf_nxt   = r_ovf;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = '0;
          w_q_nxt     = bus.multiplier;
          w_q1_nxt    = 1'b0;
          w_m_nxt     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a_nxt   = w_a_sh;
        w_q_nxt   = w_q_sh;
        w_q1_nxt  = r_q[0];
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          w_prod_nxt  = w_prod_fin;
`ifdef MULT_OVF_FLAG_EN
          w_ovf_nxt   = w_ovf_fin;
`endif
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_prod;
`ifdef MULT_OVF_FLAG_EN
  assign bus.ovf     = r_ovf;
`endif
endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(W)) ifc ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: an accepted start yields the true signed product
  // exactly W clocks later; product and ovf hold until then.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [63:0] m_prod = '0;
  bit          m_ovf  = 1'b0;
  int          m_left = 0;
  longint      m_pend = 0;

  always @(posedge clk) begin
    longint pa, pb;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_ovf = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = m_pend;
          m_ovf  = (m_pend > 64'sd2147483647) || (m_pend < -64'sd2147483648);
        end
      end else if (ifc.start) begin
        pa = $signed(ifc.multiplicand);
        pb = $signed(ifc.multiplier);
        m_pend = pa * pb;
        m_busy = 1'b1;
        m_left = W;
      end
    end
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk64("cyc_busy", 64'(ifc.busy), 64'(m_busy));
      chk64("cyc_done", 64'(ifc.done), 64'(m_done));
      chk64("cyc_product", ifc.product, m_prod);
`ifdef MULT_OVF_FLAG_EN
      chk64("cyc_ovf", 64'(ifc.ovf), 64'(m_ovf));
`endif
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ifc.start = 1'b1;
    ifc.multiplicand = a;
    ifc.multiplier = b;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.multiplicand = $urandom;
    ifc.multiplier = $urandom;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      ifc.multiplicand = $urandom;
      ifc.multiplier = $urandom;
      if (ifc.done) begin
        cyc = c;
        break;
      end
    end
    chk64({name, "_latency"}, 64'(cyc), 64'(W));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    int n_done;
    ifc.start = 1'b0;
    ifc.multiplicand = '0;
    ifc.multiplier = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    chk64("reset_busy", 64'(ifc.busy), 64'd0);
    chk64("reset_done", 64'(ifc.done), 64'd0);
    chk64("reset_product", ifc.product, 64'd0);

    start_op(32'd3, -32'sd5);
    wait_done("m3xm5", cyc);
    chk64("m3xm5_product", ifc.product, 64'hFFFF_FFFF_FFFF_FFF1);
    chk64("m3xm5_model", m_prod, 64'hFFFF_FFFF_FFFF_FFF1);
`ifdef MULT_OVF_FLAG_EN
    chk64("m3xm5_ovf", 64'(ifc.ovf), 64'd0);
`endif

    start_op(32'h8000_0000, 32'h8000_0000);
    wait_done("minxmin", cyc);
    chk64("minxmin_product", ifc.product, 64'h4000_0000_0000_0000);
`ifdef MULT_OVF_FLAG_EN
    chk64("minxmin_ovf", 64'(ifc.ovf), 64'd1);
`endif

    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done("maxxmax", cyc);
    chk64("maxxmax_product", ifc.product, 64'h3FFF_FFFF_0000_0001);
    start_op(32'd0, 32'h1234_5678);
    wait_done("zero", cyc);
    chk64("zero_product", ifc.product, 64'd0);

    // starts during RUN are ignored
    start_op(32'd1234, -32'sd77);
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      ifc.start = (c == 5 || c == 20);
      ifc.multiplicand = $urandom;
      ifc.multiplier = $urandom;
      @(posedge clk); #1;
      if (ifc.done) n_done++;
    end
    ifc.start = 1'b0;
    chk64("ignore_done_count", 64'(n_done), 64'd1);
    chk64("ignore_product", ifc.product, 64'hFFFF_FFFF_FFFE_8CD6);

    // reset mid-run abandons the operation
    start_op(32'd111, 32'd222);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk64("abort_busy", 64'(ifc.busy), 64'd0);
    chk64("abort_done", 64'(ifc.done), 64'd0);
    chk64("abort_product", ifc.product, 64'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ifc.done) n_done++;
    end
    chk64("abort_no_done", 64'(n_done), 64'd0);
    start_op(-32'sd6, 32'd9);
    wait_done("after_abort", cyc);
    chk64("after_abort_product", ifc.product, 64'hFFFF_FFFF_FFFF_FFCA);

    // start in the done cycle
    start_op(32'd6, 32'd7);
    wait_done("b2b_first", cyc);
    chk64("b2b_first_product", ifc.product, 64'd42);
    start_op(32'd2, 32'd7);
    chk64("b2b_busy", 64'(ifc.busy), 64'd1);
    chk64("b2b_hold_product", ifc.product, 64'd42);
    wait_done("b2b_second", cyc);
    chk64("b2b_second_product", ifc.product, 64'd14);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      int gap;
      start_op(pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 25)) @(posedge clk);
        #1;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40 && !ifc.done; c++) begin
          @(posedge clk); #1;
        end
        chk64("rnd_done_seen", 64'(ifc.done), 64'd1);
      end else begin
        wait_done("rnd", cyc);
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #0;
    end
    repeat (W + 4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
